// File: rtl/seq_check_scheduler_pkg.sv
// Shared types and defaults for the serial sequence-checker scheduler.
// Holds the FSM state encoding and the tick-count width helper.
package seq_check_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_REPORT
    } state_t;

    localparam int DEF_WORD_W     = 16;
    localparam int DEF_CLR_CYCLES = 1;
    localparam int DEF_TICK_LAT   = 1;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_check_scheduler_if.sv
// Load and result handshake bundle of the sequence-checker scheduler.
// master = host side, slave = scheduler side.
interface seq_check_scheduler_if #(
    parameter int WORD_W = seq_check_scheduler_pkg::DEF_WORD_W,
    parameter int CNT_W  = seq_check_scheduler_pkg::cnt_w(WORD_W)
);

    logic              ld_valid;
    logic              ld_ready;
    logic [WORD_W-1:0] ld_word;
    logic              ld_clr;
    logic              res_valid;
    logic              res_ready;
    logic [WORD_W-1:0] res_map;
    logic [CNT_W-1:0]  res_cnt;

    modport master (
        output ld_valid, ld_word, ld_clr, res_ready,
        input  ld_ready, res_valid, res_map, res_cnt
    );

    modport slave (
        input  ld_valid, ld_word, ld_clr, res_ready,
        output ld_ready, res_valid, res_map, res_cnt
    );

endinterface

// File: rtl/seq_shift_tx.sv
// Word shift register feeding the checker LSB-first, one bit per clock,
// plus a delayed bit-index pipe so each tick lands on the bit that caused it.
module seq_shift_tx
    import seq_check_scheduler_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int TICK_LAT = DEF_TICK_LAT,
    localparam int IW      = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    output logic              chk_bit,
    output logic              last,
    output logic              tap_v,
    output logic [IW-1:0]     tap_idx
);

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] src;
    logic [IW-1:0]     idx;
    logic              act;

    assign src  = load ? word : shreg;
    assign last = act && (idx == IW'(WORD_W - 1));

    // Capture the word, then drive one bit per cycle with no gaps
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg   <= '0;
            chk_bit <= 1'b0;
            act     <= 1'b0;
            idx     <= '0;
        end else if (start) begin
            chk_bit <= src[0];
            shreg   <= src >> 1;
            act     <= 1'b1;
            idx     <= '0;
        end else if (load) begin
            shreg <= word;
        end else if (last) begin
            act     <= 1'b0;
            chk_bit <= 1'b0;
        end else if (act) begin
            chk_bit <= shreg[0];
            shreg   <= shreg >> 1;
            idx     <= idx + IW'(1);
        end
    end

    generate
        if (TICK_LAT == 0) begin : g_nolat
            assign tap_v   = act;
            assign tap_idx = idx;
        end else begin : g_lat
            logic [TICK_LAT-1:0] vd;
            logic [IW-1:0]       id [TICK_LAT];

            // Delay the active flag and bit index by the checker latency
            always_ff @(posedge clk) begin
                if (!rst) begin
                    vd <= '0;
                    for (int i = 0; i < TICK_LAT; i++) id[i] <= '0;
                end else begin
                    vd[0] <= act;
                    id[0] <= idx;
                    for (int i = 1; i < TICK_LAT; i++) begin
                        vd[i] <= vd[i-1];
                        id[i] <= id[i-1];
                    end
                end
            end

            assign tap_v   = vd[TICK_LAT-1];
            assign tap_idx = id[TICK_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/seq_check_scheduler.sv
// Scheduler around the serial sequence checker: accepts a word, optionally
// resets the checker, shifts the word in and reports which bits ticked.
module seq_check_scheduler
    import seq_check_scheduler_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int CLR_CYCLES = DEF_CLR_CYCLES,
    parameter int TICK_LAT   = DEF_TICK_LAT,
    parameter int CNT_W      = cnt_w(WORD_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    seq_check_scheduler_if.slave        bus,
    output logic                        chk_rst,
    output logic                        chk_bit,
    input  logic                        chk_tick,
    output logic                        busy
);

    localparam int IW = $clog2(WORD_W);

    state_t            state;
    state_t            nxt;
    logic [3:0]        cnt;
    logic              hold;
    logic              accept;
    logic              start;
    logic              last;
    logic              tap_v;
    logic [IW-1:0]     tap_idx;
    logic [WORD_W-1:0] res_map;
    logic [CNT_W-1:0]  res_cnt;

    assign bus.ld_ready  = (state == S_IDLE);
    assign bus.res_valid = (state == S_REPORT);
    assign bus.res_map   = res_map;
    assign bus.res_cnt   = res_cnt;
    assign busy          = (state != S_IDLE);
    assign accept        = bus.ld_valid && bus.ld_ready;
    assign chk_rst       = hold || (state == S_CLR);

    seq_shift_tx #(
        .WORD_W  (WORD_W),
        .TICK_LAT(TICK_LAT)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .start  (start),
        .word   (bus.ld_word),
        .chk_bit(chk_bit),
        .last   (last),
        .tap_v  (tap_v),
        .tap_idx(tap_idx)
    );

    // Next state; DRAIN spans TICK_LAT+1 cycles so the last tick settles
    always_comb begin
        nxt   = state;
        start = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.ld_valid) begin
                    nxt   = bus.ld_clr ? S_CLR : S_SHIFT;
                    start = !bus.ld_clr;
                end
            end
            S_CLR: begin
                if (cnt == 4'(CLR_CYCLES - 1)) begin
                    nxt   = S_SHIFT;
                    start = 1'b1;
                end
            end
            S_SHIFT:  if (last) nxt = S_DRAIN;
            S_DRAIN:  if (cnt == 4'(TICK_LAT)) nxt = S_REPORT;
            S_REPORT: if (bus.res_ready) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // State register with a per-state cycle counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? 4'd0 : cnt + 4'd1;
        end
    end

    // Keep the checker in reset from our reset until a word arrives
    always_ff @(posedge clk) begin
        if (!rst) hold <= 1'b1;
        else if (accept) hold <= 1'b0;
    end

    // Attribute delayed ticks to bit positions; clear on each new word
    always_ff @(posedge clk) begin
        if (!rst || accept) begin
            res_map <= '0;
            res_cnt <= '0;
        end else if (tap_v && chk_tick) begin
            res_map[tap_idx] <= 1'b1;
            res_cnt          <= res_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_check_scheduler.sv
// Bench for seq_check_scheduler with a "every third one" checker model
// as the consumer; expected maps come from plain arithmetic on the words.
module tb_seq_check_scheduler;

    localparam int W    = 16;
    localparam int CLRC = 1;
    localparam int LAT  = 1;
    localparam int CW   = 5;

    logic clk = 1'b0;
    logic rst;
    logic chk_rst;
    logic chk_bit;
    logic chk_tick = 1'b0;
    logic busy;
    int   ones_mod = 0;
    int   mc;
    int   vec = 0;
    int   err = 0;

    always #5 clk = ~clk;

    seq_check_scheduler_if #(.WORD_W(W), .CNT_W(CW)) bus ();

    seq_check_scheduler #(
        .WORD_W    (W),
        .CLR_CYCLES(CLRC),
        .TICK_LAT  (LAT),
        .CNT_W     (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .chk_rst (chk_rst),
        .chk_bit (chk_bit),
        .chk_tick(chk_tick),
        .busy    (busy)
    );

    // Checker: ticks one cycle after every third 1 seen since its reset
    always @(posedge clk) begin
        if (chk_rst === 1'b1) begin
            ones_mod <= 0;
            chk_tick <= 1'b0;
        end else begin
            chk_tick <= (chk_bit === 1'b1) && (ones_mod == 2);
            if (chk_bit === 1'b1) ones_mod <= (ones_mod == 2) ? 0 : ones_mod + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_map(input logic [W-1:0] w);
        logic [W-1:0] m;
        m = '0;
        for (int k = 0; k < W; k++) begin
            if (w[k]) begin
                mc = (mc + 1) % 3;
                if (mc == 0) m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic send(input logic [W-1:0] w, input logic clr,
                        input int stall, input int rdly);
        logic [W-1:0] em;
        logic [W-1:0] stream;
        logic         saw_rst;
        int           lat;
        int           nb;
        int           i;
        if (clr) mc = 0;
        em = model_map(w);
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_word  = w;
        bus.ld_clr   = clr;
        i = 0;
        while (!bus.ld_ready && i < 100) begin
            @(negedge clk);
            i++;
        end
        check_eq("ld_ready_wait", 32'(bus.ld_ready), 32'd1);
        @(posedge clk);
        lat = 0;
        nb = 0;
        saw_rst = 1'b0;
        stream = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (n == 0) bus.ld_valid = 1'b0;
            if (chk_rst) saw_rst = 1'b1;
            else if (busy && nb < W) begin
                stream[nb] = chk_bit;
                nb++;
            end
            if (bus.res_valid) break;
            lat++;
        end
        check_eq("res_valid_wait", 32'(bus.res_valid), 32'd1);
        check_eq("latency", 32'(lat), 32'((clr ? CLRC : 0) + W + LAT + 1));
        check_eq("chk_bit_stream", 32'(stream), 32'(w));
        check_eq("chk_rst_seen", 32'(saw_rst), 32'(clr));
        check_eq("res_map", 32'(bus.res_map), 32'(em));
        check_eq("res_cnt", 32'(bus.res_cnt), 32'($countones(em)));
        for (int s = 0; s < stall; s++) begin
            bus.ld_valid = 1'b1;
            bus.ld_word  = W'($urandom);
            bus.ld_clr   = 1'($urandom);
            @(negedge clk);
            check_eq("stall_valid", 32'(bus.res_valid), 32'd1);
            check_eq("stall_map", 32'(bus.res_map), 32'(em));
            check_eq("stall_cnt", 32'(bus.res_cnt), 32'($countones(em)));
            check_eq("stall_ld_ready", 32'(bus.ld_ready), 32'd0);
        end
        bus.ld_valid = 1'b0;
        for (int d = 0; d < rdly; d++) @(negedge clk);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_eq("retire_valid", 32'(bus.res_valid), 32'd0);
        check_eq("retire_ld_ready", 32'(bus.ld_ready), 32'd1);
        check_eq("retire_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int  i;
        logic seen;
        rst           = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_word   = '0;
        bus.ld_clr    = 1'b0;
        bus.res_ready = 1'b0;
        mc            = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check_eq("rst_chk_rst", 32'(chk_rst), 32'd1);
        check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_res_map", 32'(bus.res_map), 32'd0);
        check_eq("rst_res_cnt", 32'(bus.res_cnt), 32'd0);
        check_eq("rst_chk_bit", 32'(chk_bit), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        send(16'b1011110111010000, 1'b1, 0, 0);
        send(16'h0000, 1'b1, 0, 0);
        send(16'hFFFF, 1'b1, 0, 0);
        send(16'h0003, 1'b1, 0, 0);
        send(16'h0001, 1'b0, 0, 1);
        send(16'h1249, 1'b1, 10, 0);

        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_word  = 16'hFFFF;
        bus.ld_clr   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        i = 0;
        while (chk_rst && i < 50) begin
            @(negedge clk);
            i++;
        end
        check_eq("abort_shift_start", 32'(chk_rst), 32'd0);
        repeat (7) @(negedge clk);
        check_eq("abort_bit7", 32'(chk_bit), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_ld_ready", 32'(bus.ld_ready), 32'd1);
        check_eq("abort_chk_rst", 32'(chk_rst), 32'd1);
        check_eq("abort_chk_bit", 32'(chk_bit), 32'd0);
        rst = 1'b1;
        mc = 0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        check_eq("abort_no_result", 32'(seen), 32'd0);
        send(16'b1011110111010000, 1'b0, 0, 0);

        repeat (25) begin
            send(W'($urandom), ($urandom_range(0, 3) == 0), 0,
                 int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
